sobel_sim_top: RTL and testbench

Self-contained simulation top for the Sobel edge-detection datapath. It contains a synthetic frame generator, a two-row line buffer with a 3×3 window, and a Sobel gradient-magnitude stage. No external stimulus is needed: after reset it streams one pixel per clock indefinitely. It exposes the generated pixel and the resulting edge value on debug ports for waveform and `$monitor` inspection.

---
 rtl/sobel_sim_pkg.sv | 11 +
 rtl/sobel_sim_if.sv | 9 +
 rtl/sobel_kernel3x3.sv | 16 +
 rtl/sobel_sim_top.sv | 79 +++++++
 tb/tb_sobel_sim_top.sv | 81 ++++++++
 5 files changed

// File: rtl/sobel_sim_pkg.sv
// sobel_sim_pkg: shared pixel/gradient types, constants and the Sobel tap helper.
package sobel_sim_pkg;
  typedef logic [7:0] pixel_t;
  typedef logic signed [10:0] grad_t;
  localparam pixel_t PIX_SAT = 8'hFF;
  localparam pixel_t PIX_LO_DEF = 8'h20;
  localparam pixel_t PIX_HI_DEF = 8'hE0;
  function automatic logic [10:0] tap(pixel_t a, pixel_t b, pixel_t c);
    return {3'b0, a} + {2'b0, b, 1'b0} + {3'b0, c};
  endfunction
endpackage

// File: rtl/sobel_sim_if.sv
// sobel_sim_if: debug observation bundle for the Sobel simulation top.
interface sobel_sim_if;
  import sobel_sim_pkg::*;
  pixel_t pixel_in_dbg;
  pixel_t edge_out_dbg;
  logic edge_valid_dbg;
  modport master(output pixel_in_dbg, edge_out_dbg, edge_valid_dbg);
  modport slave(input pixel_in_dbg, edge_out_dbg, edge_valid_dbg);
endinterface

// File: rtl/sobel_kernel3x3.sv
// sobel_kernel3x3: combinational |Gx|+|Gy| over a 3x3 window, saturated to 8 bits.
module sobel_kernel3x3 import sobel_sim_pkg::*; (
  input  pixel_t win [3][3],
  output pixel_t mag
);
  grad_t gx, gy, ax, ay;
  logic [11:0] sum;
  always_comb begin
    gx = grad_t'(tap(win[0][2], win[1][2], win[2][2]) - tap(win[0][0], win[1][0], win[2][0]));
    gy = grad_t'(tap(win[2][0], win[2][1], win[2][2]) - tap(win[0][0], win[0][1], win[0][2]));
    ax = gx[10] ? -gx : gx;
    ay = gy[10] ? -gy : gy;
    sum = {1'b0, ax} + {1'b0, ay};
    mag = |sum[11:8] ? PIX_SAT : sum[7:0];
  end
endmodule

// File: rtl/sobel_sim_top.sv
// sobel_sim_top: quadrant frame generator, two-row line buffer, 3x3 window and Sobel output stage.
// Optional macro SOBEL_THRESH_EN binarizes the magnitude against THRESH.
module sobel_sim_top import sobel_sim_pkg::*; #(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8,
  parameter pixel_t PIX_LO = PIX_LO_DEF,
  parameter pixel_t PIX_HI = PIX_HI_DEF,
  parameter int THRESH = 128
) (
  input logic clk,
  input logic rst,
  sobel_sim_if.master dbg
);
  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);
  logic [XW-1:0] x_q, x_d, px_q, px_d;
  logic [YW-1:0] y_q, y_d, py_q, py_d;
  pixel_t pix_q, pix_d, edge_q, edge_d, mag, res;
  logic wv_q, wv_d, ev_q, ev_d;
  pixel_t win_q [3][3];
  pixel_t win_d [3][3];
  pixel_t lb1_q [IMG_W];
  pixel_t lb2_q [IMG_W];
  sobel_kernel3x3 u_kernel (.win(win_q), .mag(mag));
`ifdef SOBEL_THRESH_EN
  assign res = (mag >= 8'(THRESH)) ? PIX_SAT : '0;
`else
  assign res = mag;
`endif
  // px/py track the coordinate of the pixel currently held in pix_q
  always_comb begin
    x_d = (x_q == XW'(IMG_W - 1)) ? '0 : x_q + 1'b1;
    y_d = (x_q != XW'(IMG_W - 1)) ? y_q : (y_q == YW'(IMG_H - 1)) ? '0 : y_q + 1'b1;
    pix_d = ((x_q >= XW'(IMG_W / 2)) ^ (y_q >= YW'(IMG_H / 2))) ? PIX_HI : PIX_LO;
    px_d = x_q;
    py_d = y_q;
    for (int r = 0; r < 3; r++) begin
      win_d[r][0] = win_q[r][1];
      win_d[r][1] = win_q[r][2];
    end
    win_d[0][2] = lb2_q[px_q];
    win_d[1][2] = lb1_q[px_q];
    win_d[2][2] = pix_q;
    wv_d = (px_q >= XW'(2)) && (py_q >= YW'(2));
    ev_d = wv_q;
    edge_d = wv_q ? res : '0;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q <= '0;
      y_q <= '0;
      px_q <= '0;
      py_q <= '0;
      pix_q <= '0;
      win_q <= '{default: '0};
      wv_q <= 1'b0;
      ev_q <= 1'b0;
      edge_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
      px_q <= px_d;
      py_q <= py_d;
      pix_q <= pix_d;
      win_q <= win_d;
      wv_q <= wv_d;
      ev_q <= ev_d;
      edge_q <= edge_d;
    end
  end
  // stale rows left over from a previous frame are masked by the validity pipeline
  always_ff @(posedge clk) begin
    lb1_q[px_q] <= pix_q;
    lb2_q[px_q] <= lb1_q[px_q];
  end
  assign dbg.pixel_in_dbg = pix_q;
  assign dbg.edge_out_dbg = edge_q;
  assign dbg.edge_valid_dbg = ev_q;
endmodule

// File: tb/tb_sobel_sim_top.sv
// tb_sobel_sim_top: directed checks of reset, latency, per-centre edge values, frame wrap and mid-frame reset.
module tb_sobel_sim_top;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  sobel_sim_if dbg ();
  sobel_sim_top dut (.clk(clk), .rst(rst), .dbg(dbg));
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  // 8x8 quadrant checkerboard: bright where exactly one of x>=4, y>=4 holds
  function automatic logic [7:0] pat(int x, int y);
    return ((x >= 4) ^ (y >= 4)) ? 8'hE0 : 8'h20;
  endfunction
  // hand-derived: any window touching the x=3/4 or y=3/4 boundary has |G| >= 384, flat windows give 0
  function automatic logic [7:0] edge_exp(int cx, int cy);
    return (cx == 3 || cx == 4 || cy == 3 || cy == 4) ? 8'hFF : 8'h00;
  endfunction
  task automatic cycle_check(int n, inout int first_valid, inout int vcnt0, inout int vcnt1);
    int i, j, jx, jy;
    logic v;
    i = n - 1;
    chk($sformatf("pix n=%0d", n), dbg.pixel_in_dbg, pat(i % 8, (i / 8) % 8));
    j = n - 3;
    jx = j % 8;
    jy = (j / 8) % 8;
    v = (j >= 0) && (jx >= 2) && (jy >= 2);
    chk($sformatf("valid n=%0d", n), dbg.edge_valid_dbg, v);
    chk($sformatf("edge c(%0d,%0d) n=%0d", jx - 1, jy - 1, n), dbg.edge_out_dbg,
        v ? edge_exp(jx - 1, jy - 1) : 8'h00);
    if (v && first_valid == 0) first_valid = n;
    if (v && j < 64) vcnt0++;
    if (v && j >= 64 && j < 128) vcnt1++;
  endtask
  initial begin
    int fv, c0, c1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset pix", dbg.pixel_in_dbg, 8'h00);
    chk("reset edge", dbg.edge_out_dbg, 8'h00);
    chk("reset valid", dbg.edge_valid_dbg, 1'b0);
    rst = 1'b0;
    fv = 0;
    c0 = 0;
    c1 = 0;
    for (int n = 1; n <= 130; n++) begin
      @(posedge clk);
      @(negedge clk);
      cycle_check(n, fv, c0, c1);
    end
    chk("first valid cycle", fv, 21);
    chk("frame1 valid count", c0, 36);
    chk("frame2 valid count", c1, 36);
    rst = 1'b1;
    #1;
    chk("async reset pix", dbg.pixel_in_dbg, 8'h00);
    chk("async reset valid", dbg.edge_valid_dbg, 1'b0);
    chk("async reset edge", dbg.edge_out_dbg, 8'h00);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    fv = 0;
    c0 = 0;
    c1 = 0;
    for (int n = 1; n <= 30; n++) begin
      @(posedge clk);
      @(negedge clk);
      cycle_check(n, fv, c0, c1);
    end
    chk("first valid after mid reset", fv, 21);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
